// File: rtl/text_cursor_writer_if.sv
// Character-in / RAM-write-out bundle for text_cursor_writer.
// Ports (slave view):
//   i_ena, i_data[7:0], i_valid          upstream character stream and enable
//   o_ready                              block accepts a character this cycle
//   o_address[LIN_W+COL_W-1:0], o_data,  text RAM write port, address = {lin, col}
//   o_we
//   o_col, o_lin                         current cursor position
interface text_cursor_writer_if #(
    parameter int unsigned COL_W = 6,
    parameter int unsigned LIN_W = 5
);
    logic                     i_ena;
    logic [7:0]               i_data;
    logic                     i_valid;
    logic                     o_ready;
    logic [LIN_W+COL_W-1:0]   o_address;
    logic [7:0]               o_data;
    logic                     o_we;
    logic [COL_W-1:0]         o_col;
    logic [LIN_W-1:0]         o_lin;

    // Upstream source / RAM side
    modport master (
        output i_ena, i_data, i_valid,
        input  o_ready, o_address, o_data, o_we, o_col, o_lin
    );

    // The cursor writer itself
    modport slave (
        input  i_ena, i_data, i_valid,
        output o_ready, o_address, o_data, o_we, o_col, o_lin
    );
endinterface

// File: rtl/text_cursor_writer.sv
// Cursor-driven text RAM writer: accepts characters over valid/ready, writes
// printable codes at {lin, col}, interprets CR/LF/BS/TAB/FF and optionally
// blanks every newly entered line.
// Ports:
//   i_clk   system clock, posedge
//   i_rst   asynchronous reset, active-high
//   bus     text_cursor_writer_if.slave (character input, RAM write, cursor)
module text_cursor_writer #(
    parameter int unsigned COLS          = 60,
    parameter int unsigned LINES         = 17,
    parameter int unsigned COL_W         = 6,
    parameter int unsigned LIN_W         = 5,
    parameter int unsigned TAB_W         = 8,
    parameter int unsigned CLEAR_NEWLINE = 1,
    parameter logic [7:0]  BLANK         = 8'h20
) (
    input logic i_clk,
    input logic i_rst,
    text_cursor_writer_if.slave bus
);

    localparam int unsigned   CX_W     = COL_W + 1;
    localparam logic [7:0]    CH_BS    = 8'h08;
    localparam logic [7:0]    CH_TAB   = 8'h09;
    localparam logic [7:0]    CH_LF    = 8'h0A;
    localparam logic [7:0]    CH_FF    = 8'h0C;
    localparam logic [7:0]    CH_CR    = 8'h0D;
    localparam logic [CX_W-1:0] COLS_X   = CX_W'(COLS);
    localparam logic [CX_W-1:0] TAB_X    = CX_W'(TAB_W);
    localparam logic [CX_W-1:0] TAB_MASK = ~CX_W'(TAB_W - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [LIN_W-1:0] LIN_LAST = LIN_W'(LINES - 1);

    typedef enum logic [1:0] {IDLE, PROC, CLRLINE, CLRSCR} state_t;

    state_t                 state;
    logic [COL_W-1:0]       col;
    logic [LIN_W-1:0]       lin;
    logic [7:0]             ch;
    logic [COL_W-1:0]       clr_col;
    logic [LIN_W-1:0]       clr_lin;
    logic                   ready_q;
    logic                   we_q;
    logic [LIN_W+COL_W-1:0] addr_q;
    logic [7:0]             data_q;

    logic [CX_W-1:0]  col_inc;
    logic [CX_W-1:0]  tab_nc;
    logic [COL_W-1:0] col_dec;
    logic [LIN_W-1:0] lin_next;
    logic             accept;

    // Decode of the latched character, consumed in PROC
    logic [COL_W-1:0] nxt_col;
    logic [LIN_W-1:0] nxt_lin;
    logic             nl;
    logic             scr;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

    // Column math is one bit wider than the field so COLS compares never wrap
    assign col_inc  = {1'b0, col} + 1'b1;
    assign tab_nc   = ({1'b0, col} & TAB_MASK) + TAB_X;
    assign col_dec  = col - 1'b1;
    assign lin_next = (lin == LIN_LAST) ? '0 : lin + 1'b1;
    assign accept   = bus.i_valid & ready_q;

    always_comb begin
        nxt_col = col;
        nxt_lin = lin;
        nl      = 1'b0;
        scr     = 1'b0;
        case (ch)
            CH_LF: begin
                nxt_lin = lin_next;
                nl      = 1'b1;
            end
            CH_CR: nxt_col = '0;
            CH_BS: begin
                if (col != '0) nxt_col = col_dec;
            end
            CH_TAB: begin
                if (tab_nc < COLS_X) begin
                    nxt_col = tab_nc[COL_W-1:0];
                end else begin
                    nxt_col = '0;
                    nxt_lin = lin_next;
                    nl      = 1'b1;
                end
            end
            CH_FF: begin
                nxt_col = '0;
                nxt_lin = '0;
                scr     = 1'b1;
            end
            default: begin
                if (is_printable(ch)) begin
                    if (col_inc < COLS_X) begin
                        nxt_col = col_inc[COL_W-1:0];
                    end else begin
                        nxt_col = '0;
                        nxt_lin = lin_next;
                        nl      = 1'b1;
                    end
                end
            end
        endcase
    end

    // Control FSM with registered write port, ready and cursor
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            col     <= '0;
            lin     <= '0;
            ch      <= '0;
            clr_col <= '0;
            clr_lin <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            we_q    <= 1'b0;
            ready_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Writes that depend only on the incoming code are issued
                        // right away so they appear the cycle after acceptance
                        ch    <= bus.i_data;
                        state <= PROC;
                        if (is_printable(bus.i_data)) begin
                            we_q   <= 1'b1;
                            addr_q <= {lin, col};
                            data_q <= bus.i_data;
                        end else if (bus.i_data == CH_BS && col != '0) begin
                            we_q   <= 1'b1;
                            addr_q <= {lin, col_dec};
                            data_q <= BLANK;
                        end
                    end else begin
                        ready_q <= bus.i_ena;
                    end
                end
                PROC: begin
                    col     <= nxt_col;
                    lin     <= nxt_lin;
                    clr_col <= '0;
                    clr_lin <= '0;
                    if (scr) begin
                        state <= CLRSCR;
                    end else if (nl && CLEAR_NEWLINE != 0) begin
                        state <= CLRLINE;
                    end else begin
                        state   <= IDLE;
                        ready_q <= bus.i_ena;
                    end
                end
                CLRLINE: begin
                    we_q   <= 1'b1;
                    addr_q <= {lin, clr_col};
                    data_q <= BLANK;
                    if (clr_col == COL_LAST) begin
                        state <= IDLE;
                    end else begin
                        clr_col <= clr_col + 1'b1;
                    end
                end
                CLRSCR: begin
                    we_q   <= 1'b1;
                    addr_q <= {clr_lin, clr_col};
                    data_q <= BLANK;
                    if (clr_col == COL_LAST) begin
                        clr_col <= '0;
                        if (clr_lin == LIN_LAST) begin
                            state <= IDLE;
                        end else begin
                            clr_lin <= clr_lin + 1'b1;
                        end
                    end else begin
                        clr_col <= clr_col + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_ready   = ready_q;
    assign bus.o_we      = we_q;
    assign bus.o_address = addr_q;
    assign bus.o_data    = data_q;
    assign bus.o_col     = col;
    assign bus.o_lin     = lin;

endmodule

// File: tb/tb_text_cursor_writer.sv
// Bench for text_cursor_writer: directed timing checks, a vector table,
// hand-written corner sequences and random traffic against a screen-level model.
module tb_text_cursor_writer;

    localparam int unsigned COLS  = 60;
    localparam int unsigned LINES = 17;
    localparam int unsigned COL_W = 6;
    localparam int unsigned LIN_W = 5;
    localparam int unsigned TAB_W = 8;
    localparam logic [7:0]  BLANK = 8'h20;
    localparam int unsigned WR_W  = LIN_W + COL_W + 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    text_cursor_writer_if #(.COL_W(COL_W), .LIN_W(LIN_W)) bus ();

    text_cursor_writer #(
        .COLS(COLS), .LINES(LINES), .COL_W(COL_W), .LIN_W(LIN_W),
        .TAB_W(TAB_W), .CLEAR_NEWLINE(1), .BLANK(BLANK)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [WR_W-1:0] got_q[$];
    logic [WR_W-1:0] exp_q[$];
    int   ready_overlap = 0;
    int   bursts = 0;
    logic prev_we = 1'b0;
    int   m_col;
    int   m_lin;

    // Write-port monitor
    always @(negedge clk) begin
        if (bus.o_we === 1'b1) begin
            got_q.push_back({bus.o_address, bus.o_data});
            if (bus.o_ready !== 1'b0) ready_overlap++;
            if (prev_we !== 1'b1) bursts++;
        end
        prev_we = bus.o_we;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [WR_W-1:0] wr(input int l, input int c, input logic [7:0] d);
        return {LIN_W'(l), COL_W'(c), d};
    endfunction

    function automatic logic [63:0] got_at(input int i);
        if (i < got_q.size()) return 64'(got_q[i]);
        return '1;
    endfunction

    // Screen-level reference: cursor as integers, expected writes as a list
    task automatic model_newline();
        for (int c = 0; c < COLS; c++) exp_q.push_back(wr(m_lin, c, BLANK));
    endtask

    task automatic model_next_line();
        m_col = 0;
        m_lin = (m_lin + 1) % LINES;
        model_newline();
    endtask

    task automatic model_char(input logic [7:0] c);
        int nc;
        if (c >= 8'h20 && c <= 8'h7E) begin
            exp_q.push_back(wr(m_lin, m_col, c));
            if (m_col < COLS - 1) m_col++;
            else model_next_line();
        end else if (c == 8'h0A) begin
            m_lin = (m_lin + 1) % LINES;
            model_newline();
        end else if (c == 8'h0D) begin
            m_col = 0;
        end else if (c == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                exp_q.push_back(wr(m_lin, m_col, BLANK));
            end
        end else if (c == 8'h09) begin
            nc = (m_col / TAB_W + 1) * TAB_W;
            if (nc < COLS) m_col = nc;
            else model_next_line();
        end else if (c == 8'h0C) begin
            for (int l = 0; l < LINES; l++)
                for (int k = 0; k < COLS; k++)
                    exp_q.push_back(wr(l, k, BLANK));
            m_col = 0;
            m_lin = 0;
        end
    endtask

    task automatic check_writes(input string tag);
        int first_bad = -1;
        int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        check({tag, "_wr_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < n; i++)
            if (first_bad < 0 && got_q[i] !== exp_q[i]) first_bad = i;
        if (first_bad >= 0)
            $display("  detail %s: write %0d got 0x%0h expected 0x%0h",
                     tag, first_bad, got_q[first_bad], exp_q[first_bad]);
        check({tag, "_wr_first_bad_idx"}, 64'(first_bad), 64'(-1));
        check({tag, "_col"}, 64'(bus.o_col), 64'(m_col));
        check({tag, "_lin"}, 64'(bus.o_lin), 64'(m_lin));
        got_q.delete();
        exp_q.delete();
        bursts = 0;
    endtask

    // Send one character, optionally drop enable afterwards, wait for completion
    task automatic send(input logic [7:0] c, input bit ena_drop);
        int  n = 0;
        bit  rdy;
        bus.i_data  = c;
        bus.i_valid = 1'b1;
        while (1) begin
            rdy = bus.o_ready;
            @(posedge clk); #1;
            if (rdy) break;
            n++;
            if (n > 50) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        bus.i_valid = 1'b0;
        bus.i_data  = 8'($urandom);
        if (ena_drop) begin
            bus.i_ena = 1'b0;
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
            check("ready_while_disabled", 64'(bus.o_ready), 0);
            bus.i_ena = 1'b1;
        end
        n = 0;
        while (bus.o_ready !== 1'b1) begin
            @(posedge clk); #1;
            n++;
            if (n > 3000) begin
                check("done_timeout", 0, 1);
                break;
            end
        end
        model_char(c);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_ena   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        got_q.delete();
        exp_q.delete();
        bursts = 0;
        m_col  = 0;
        m_lin  = 0;
    endtask

    typedef struct {
        logic [7:0] ch;
        int         col;
        int         lin;
        int         nwr;
        int         addr;
        logic [7:0] data;
    } vec_t;

    vec_t vt[14];

    initial begin
        int    pulses;
        int    gaps;
        int    we_in_rst;
        int    r;
        logic [7:0] c;
        string tag;

        vt[0]  = '{8'h41, 1, 0, 1,  0,  8'h41};
        vt[1]  = '{8'h42, 2, 0, 1,  1,  8'h42};
        vt[2]  = '{8'h09, 8, 0, 0,  0,  8'h00};
        vt[3]  = '{8'h08, 7, 0, 1,  7,  8'h20};
        vt[4]  = '{8'h0D, 0, 0, 0,  0,  8'h00};
        vt[5]  = '{8'h08, 0, 0, 0,  0,  8'h00};
        vt[6]  = '{8'h01, 0, 0, 0,  0,  8'h00};
        vt[7]  = '{8'h80, 0, 0, 0,  0,  8'h00};
        vt[8]  = '{8'h0A, 0, 1, 60, 64, 8'h20};
        vt[9]  = '{8'h7A, 1, 1, 1,  64, 8'h7A};
        vt[10] = '{8'h7F, 1, 1, 0,  0,  8'h00};
        vt[11] = '{8'h09, 8, 1, 0,  0,  8'h00};
        vt[12] = '{8'h7E, 9, 1, 1,  72, 8'h7E};
        vt[13] = '{8'h20, 10, 1, 1, 73, 8'h20};

        // Reset values and first-transaction timing with i_valid held through reset
        rst = 1'b1;
        bus.i_ena   = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_data  = 8'h41;
        m_col = 0;
        m_lin = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_we",      64'(bus.o_we), 0);
        check("rst_address", 64'(bus.o_address), 0);
        check("rst_data",    64'(bus.o_data), 0);
        check("rst_ready",   64'(bus.o_ready), 0);
        check("rst_col",     64'(bus.o_col), 0);
        check("rst_lin",     64'(bus.o_lin), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_rise", 64'(bus.o_ready), 1);
        check("no_early_we", 64'(bus.o_we), 0);
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        check("A_ready_busy", 64'(bus.o_ready), 0);
        check("A_we",         64'(bus.o_we), 1);
        check("A_address",    64'(bus.o_address), 0);
        check("A_data",       64'(bus.o_data), 64'h41);
        @(posedge clk); #1;
        check("A_we_drop",    64'(bus.o_we), 0);
        check("A_ready_back", 64'(bus.o_ready), 1);
        model_char(8'h41);
        check_writes("A");

        // Vector table from a fresh reset
        do_reset();
        for (int i = 0; i < 14; i++) begin
            tag = $sformatf("vec%0d", i);
            send(vt[i].ch, 1'b0);
            check({tag, "_nwr"}, 64'(got_q.size()), 64'(vt[i].nwr));
            if (vt[i].nwr > 0)
                check({tag, "_first_wr"}, got_at(0), 64'(wr(vt[i].addr / 64, vt[i].addr % 64, vt[i].data)));
            check({tag, "_col_const"}, 64'(bus.o_col), 64'(vt[i].col));
            check({tag, "_lin_const"}, 64'(bus.o_lin), 64'(vt[i].lin));
            check_writes(tag);
        end

        // 60 printables wrap into a line clear
        do_reset();
        for (int i = 0; i < 59; i++) begin
            send(8'h78, 1'b0);
            check_writes("x_fill");
        end
        send(8'h78, 1'b0);
        check("x60_nwr",   64'(got_q.size()), 61);
        check("x60_first", got_at(0),  64'(wr(0, 59, 8'h78)));
        check("x60_clr0",  got_at(1),  64'(wr(1, 0, BLANK)));
        check("x60_last",  got_at(60), 64'(wr(1, 59, BLANK)));
        check("x60_col",   64'(bus.o_col), 0);
        check("x60_lin",   64'(bus.o_lin), 1);
        check_writes("x60");

        // LF on the last line wraps to line 0 and keeps the column
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send(8'h0A, 1'b0);
            check_writes("lf_walk");
        end
        for (int i = 0; i < 5; i++) begin
            send(8'h61, 1'b0);
            check_writes("lf_pos");
        end
        send(8'h0A, 1'b0);
        check("lfwrap_col",   64'(bus.o_col), 5);
        check("lfwrap_lin",   64'(bus.o_lin), 0);
        check("lfwrap_nwr",   64'(got_q.size()), 60);
        check("lfwrap_first", got_at(0),  64'(wr(0, 0, BLANK)));
        check("lfwrap_last",  got_at(59), 64'(wr(0, 59, BLANK)));
        check_writes("lfwrap");

        // TAB inside the line and past the last stop
        do_reset();
        for (int i = 0; i < 13; i++) begin
            send(8'h62, 1'b0);
            check_writes("tab_pos");
        end
        send(8'h09, 1'b0);
        check("tab13_col", 64'(bus.o_col), 16);
        check("tab13_nwr", 64'(got_q.size()), 0);
        check_writes("tab13");
        for (int i = 0; i < 42; i++) begin
            send(8'h63, 1'b0);
            check_writes("tab_pos2");
        end
        check("tab58_start", 64'(bus.o_col), 58);
        send(8'h09, 1'b0);
        check("tab58_col",   64'(bus.o_col), 0);
        check("tab58_lin",   64'(bus.o_lin), 1);
        check("tab58_nwr",   64'(got_q.size()), 60);
        check("tab58_first", got_at(0), 64'(wr(1, 0, BLANK)));
        check_writes("tab58");

        // CR and BS edge cases
        do_reset();
        for (int i = 0; i < 20; i++) send(8'h64, 1'b0);
        check_writes("cr_pos");
        send(8'h0D, 1'b0);
        check("cr_col", 64'(bus.o_col), 0);
        check("cr_nwr", 64'(got_q.size()), 0);
        check_writes("cr");
        send(8'h08, 1'b0);
        check("bs0_col", 64'(bus.o_col), 0);
        check("bs0_nwr", 64'(got_q.size()), 0);
        check_writes("bs0");
        for (int i = 0; i < 3; i++) send(8'h65, 1'b0);
        check_writes("bs_pos");
        send(8'h08, 1'b0);
        check("bs3_col", 64'(bus.o_col), 2);
        check("bs3_nwr", 64'(got_q.size()), 1);
        check("bs3_wr",  got_at(0), 64'(wr(0, 2, BLANK)));
        check_writes("bs3");

        // Full-screen clear
        send(8'h0C, 1'b0);
        check("ff_nwr",    64'(got_q.size()), 1020);
        check("ff_first",  got_at(0),    64'(wr(0, 0, BLANK)));
        check("ff_last",   got_at(1019), 64'(wr(16, 59, BLANK)));
        check("ff_bursts", 64'(bursts), 1);
        check_writes("ff");

        // Full-screen clear aborted by reset at the 500th pulse
        for (int i = 0; i < 7; i++) send(8'h66, 1'b0);
        check_writes("ffabort_pos");
        bus.i_data  = 8'h0C;
        bus.i_valid = 1'b1;
        pulses = 0;
        while (bus.o_ready !== 1'b1 && pulses < 50) begin
            @(posedge clk); #1;
            pulses++;
        end
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        pulses = 0;
        gaps   = 0;
        for (int i = 0; i < 1100; i++) begin
            @(posedge clk); #1;
            if (bus.o_we === 1'b1) pulses++;
            else if (pulses > 0) gaps++;
            if (pulses == 500) break;
        end
        check("ffabort_pulses", 64'(pulses), 500);
        check("ffabort_gaps",   64'(gaps), 0);
        rst = 1'b1;
        #1;
        check("ffabort_we",    64'(bus.o_we), 0);
        check("ffabort_col",   64'(bus.o_col), 0);
        check("ffabort_lin",   64'(bus.o_lin), 0);
        check("ffabort_ready", 64'(bus.o_ready), 0);
        we_in_rst = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.o_we !== 1'b0) we_in_rst++;
        end
        check("ffabort_we_hold", 64'(we_in_rst), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ffabort_ready_back", 64'(bus.o_ready), 1);
        check("ffabort_no_resume",  64'(bus.o_we), 0);
        got_q.delete();
        exp_q.delete();
        bursts = 0;
        m_col = 0;
        m_lin = 0;

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      c = 8'($urandom_range(32, 126));
            else if (r < 68) c = 8'h0A;
            else if (r < 74) c = 8'h0D;
            else if (r < 80) c = 8'h08;
            else if (r < 88) c = 8'h09;
            else if (r < 90) c = 8'h0C;
            else if (r < 95) c = 8'($urandom_range(0, 31));
            else             c = 8'($urandom_range(127, 255));
            send(c, $urandom_range(0, 7) == 0);
            check_writes($sformatf("rnd%0d_ch%02h", i, c));
        end

        check("ready_during_write", 64'(ready_overlap), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
